// File: rtl/sparc_pipe_pkg.sv
// Shared definitions for the SPARC pipeline hazard controller: forwarding
// select encodings, controller FSM states and the default watchdog limit.
package sparc_pipe_pkg;

  localparam int MEM_TIMEOUT_DEFAULT = 64;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_sel_e;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } hz_state_e;

  function automatic logic reg_match(input logic en, input logic [4:0] dst,
                                     input logic [4:0] src);
    return en && (dst == src);
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Priority forwarding compare for one ID-stage operand (EX > MEM > WB > RF).
module hazard_fwd_sel
  import sparc_pipe_pkg::*;
(
  input  logic [4:0] opnd,
  input  logic [4:0] ex_rd,
  input  logic       ex_rf_en,
  input  logic       ex_load,
  input  logic [4:0] mem_rd,
  input  logic       mem_rf_en,
  input  logic [4:0] wb_rd,
  input  logic       wb_rf_en,
  output logic [1:0] sel
);

  always_comb begin
    sel = FWD_RF;
    // %g0 is hardwired zero and never forwarded; a load in EX has no data yet.
    if (opnd != 5'd0) begin
      if (reg_match(ex_rf_en && !ex_load, ex_rd, opnd))
        sel = FWD_EX;
      else if (reg_match(mem_rf_en, mem_rd, opnd))
        sel = FWD_MEM;
      else if (reg_match(wb_rf_en, wb_rd, opnd))
        sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage SPARC hazard controller: forwarding, load-use stall, a-bit annul,
// memory freeze with watchdog. Optional stall counter under HAZARD_STATS_EN.
module pipeline_hazard_ctrl
  import sparc_pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] ID_rs1,
  input  logic [4:0] ID_rs2,
  input  logic [4:0] ID_rd,
  input  logic       ID_use_rs1,
  input  logic       ID_use_rs2,
  input  logic       ID_use_rd,
  input  logic       ID_branch,
  input  logic       ID_annul,
  input  logic       ID_taken,
  input  logic       ID_always,
  input  logic [4:0] EX_RD,
  input  logic       EX_rf_en,
  input  logic       EX_load,
  input  logic [4:0] MEM_RD,
  input  logic       MEM_rf_en,
  input  logic       MEM_access,
  input  logic       mem_ready,
  input  logic [4:0] WB_RD,
  input  logic       WB_rf_en,
  output logic       PC_LE,
  output logic       IF_ID_LE,
  output logic       ID_EX_LE,
  output logic       EX_MEM_LE,
  output logic       ID_EX_clr,
  output logic       MEM_WB_clr,
  output logic [1:0] fwd_MX1,
  output logic [1:0] fwd_MX2,
  output logic [1:0] fwd_MX3,
  output logic       mem_timeout
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0] stall_cycles
`endif
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  hz_state_e     state_reg, state_next;
  logic          annul_pending_reg, annul_pending_next;
  logic [CW-1:0] wait_cnt_reg, wait_cnt_next;

  logic       freeze, load_use, annul_set;
  logic [4:0] opnd    [3];
  logic       use_op  [3];
  logic [1:0] sel     [3];
  logic [2:0] op_hit;

  assign opnd[0]   = ID_rs1;
  assign opnd[1]   = ID_rs2;
  assign opnd[2]   = ID_rd;
  assign use_op[0] = ID_use_rs1;
  assign use_op[1] = ID_use_rs2;
  assign use_op[2] = ID_use_rd;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_opnd
      hazard_fwd_sel u_fwd_sel (
        .opnd      (opnd[gi]),
        .ex_rd     (EX_RD),
        .ex_rf_en  (EX_rf_en),
        .ex_load   (EX_load),
        .mem_rd    (MEM_RD),
        .mem_rf_en (MEM_rf_en),
        .wb_rd     (WB_RD),
        .wb_rf_en  (WB_rf_en),
        .sel       (sel[gi])
      );
      assign op_hit[gi] = use_op[gi] && (opnd[gi] == EX_RD);
    end
  endgenerate

  assign freeze = (state_reg == ST_ERR) ||
                  (!mem_ready && ((state_reg == ST_MEM_WAIT) ||
                                  (state_reg == ST_RUN && MEM_access)));

  // A pending annul already turns the delay slot into a bubble, so a load-use
  // match against that slot is meaningless and is ignored.
  assign load_use = !freeze && !annul_pending_reg && EX_load && EX_rf_en &&
                    (EX_RD != 5'd0) && (|op_hit);

  assign annul_set = ID_branch && ID_annul && (!ID_taken || ID_always);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= ST_RUN;
      annul_pending_reg <= 1'b0;
      wait_cnt_reg      <= '0;
    end else begin
      state_reg         <= state_next;
      annul_pending_reg <= annul_pending_next;
      wait_cnt_reg      <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next         = state_reg;
    wait_cnt_next      = wait_cnt_reg;
    annul_pending_next = annul_pending_reg;
    PC_LE              = 1'b1;
    IF_ID_LE           = 1'b1;
    ID_EX_LE           = 1'b1;
    EX_MEM_LE          = 1'b1;
    ID_EX_clr          = 1'b0;
    MEM_WB_clr         = 1'b0;

    case (state_reg)
      ST_RUN: begin
        if (MEM_access && !mem_ready) begin
          state_next    = ST_MEM_WAIT;
          wait_cnt_next = '0;
        end
      end
      ST_MEM_WAIT: begin
        // Timeout compares the count before this cycle's increment.
        if (mem_ready)
          state_next = ST_RUN;
        else if (wait_cnt_reg == CW'(MEM_TIMEOUT - 1))
          state_next = ST_ERR;
        else
          wait_cnt_next = wait_cnt_reg + CW'(1);
      end
      ST_ERR:  ;
      default: state_next = ST_RUN;
    endcase

    if (!freeze)
      annul_pending_next = !annul_pending_reg && !load_use && annul_set;

    if (reset) begin
      ID_EX_clr  = 1'b1;
      MEM_WB_clr = 1'b1;
    end else if (freeze) begin
      PC_LE      = 1'b0;
      IF_ID_LE   = 1'b0;
      ID_EX_LE   = 1'b0;
      EX_MEM_LE  = 1'b0;
      MEM_WB_clr = 1'b1;
    end else begin
      if (load_use) begin
        PC_LE     = 1'b0;
        IF_ID_LE  = 1'b0;
        ID_EX_clr = 1'b1;
      end
      if (annul_pending_reg)
        ID_EX_clr = 1'b1;
    end
  end

  assign fwd_MX1     = reset ? FWD_RF : sel[0];
  assign fwd_MX2     = reset ? FWD_RF : sel[1];
  assign fwd_MX3     = reset ? FWD_RF : sel[2];
  assign mem_timeout = !reset && (state_reg == ST_ERR);

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt_reg <= '0;
    else if (!PC_LE && stall_cnt_reg != 16'hFFFF)
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
  end

  assign stall_cycles = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl against a behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] ID_rs1, ID_rs2, ID_rd, EX_RD, MEM_RD, WB_RD;
  logic       ID_use_rs1, ID_use_rs2, ID_use_rd;
  logic       ID_branch, ID_annul, ID_taken, ID_always;
  logic       EX_rf_en, EX_load, MEM_rf_en, MEM_access, mem_ready, WB_rf_en;
  logic       PC_LE, IF_ID_LE, ID_EX_LE, EX_MEM_LE, ID_EX_clr, MEM_WB_clr;
  logic [1:0] fwd_MX1, fwd_MX2, fwd_MX3;
  logic       mem_timeout;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cycles;
`endif

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_rd(ID_rd),
    .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2), .ID_use_rd(ID_use_rd),
    .ID_branch(ID_branch), .ID_annul(ID_annul), .ID_taken(ID_taken), .ID_always(ID_always),
    .EX_RD(EX_RD), .EX_rf_en(EX_rf_en), .EX_load(EX_load),
    .MEM_RD(MEM_RD), .MEM_rf_en(MEM_rf_en), .MEM_access(MEM_access),
    .mem_ready(mem_ready), .WB_RD(WB_RD), .WB_rf_en(WB_rf_en),
    .PC_LE(PC_LE), .IF_ID_LE(IF_ID_LE), .ID_EX_LE(ID_EX_LE), .EX_MEM_LE(EX_MEM_LE),
    .ID_EX_clr(ID_EX_clr), .MEM_WB_clr(MEM_WB_clr),
    .fwd_MX1(fwd_MX1), .fwd_MX2(fwd_MX2), .fwd_MX3(fwd_MX3),
    .mem_timeout(mem_timeout)
`ifdef HAZARD_STATS_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: "waiting" means a data access has been outstanding for
  // at least one full cycle; "waited" counts those cycles.
  bit          m_wait, m_err, m_annul, n_wait, n_err, n_annul;
  int          m_waited, n_waited, m_stall, n_stall;
  logic [12:0] exp_vec;

  function automatic logic [1:0] ref_fwd(input logic [4:0] r);
    if (r == 5'd0) return 2'b00;
    if (EX_rf_en && EX_RD == r && !EX_load) return 2'b01;
    if (MEM_rf_en && MEM_RD == r) return 2'b10;
    if (WB_rf_en && WB_RD == r) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [12:0] obs_vec();
    return {PC_LE, IF_ID_LE, ID_EX_LE, EX_MEM_LE, ID_EX_clr, MEM_WB_clr,
            fwd_MX1, fwd_MX2, fwd_MX3, mem_timeout};
  endfunction

  task automatic model_eval();
    bit frz, lu, hit;
    logic [3:0] le;
    logic idc, mwc;
    frz = m_err || (!mem_ready && (m_wait || MEM_access));
    hit = (ID_use_rs1 && ID_rs1 == EX_RD) || (ID_use_rs2 && ID_rs2 == EX_RD) ||
          (ID_use_rd && ID_rd == EX_RD);
    lu  = !frz && !m_annul && EX_load && EX_rf_en && EX_RD != 5'd0 && hit;
    le = 4'hF; idc = 1'b0; mwc = 1'b0;
    if (reset) begin
      idc = 1'b1; mwc = 1'b1;
    end else if (frz) begin
      le = 4'h0; mwc = 1'b1;
    end else begin
      if (lu) begin le = 4'b0011; idc = 1'b1; end
      if (m_annul) idc = 1'b1;
    end
    if (reset) exp_vec = {le, idc, mwc, 7'b0};
    else exp_vec = {le, idc, mwc, ref_fwd(ID_rs1), ref_fwd(ID_rs2), ref_fwd(ID_rd), m_err};
    n_wait = m_wait; n_err = m_err; n_waited = m_waited; n_annul = m_annul; n_stall = m_stall;
    if (reset) begin
      n_wait = 0; n_err = 0; n_waited = 0; n_annul = 0; n_stall = 0;
    end else begin
      if (m_err) begin
      end else if (m_wait) begin
        if (mem_ready) n_wait = 0;
        else if (m_waited == TMO - 1) begin n_err = 1; n_wait = 0; end
        else n_waited = m_waited + 1;
      end else if (MEM_access && !mem_ready) begin
        n_wait = 1; n_waited = 0;
      end
      if (!frz) n_annul = !m_annul && !lu && ID_branch && ID_annul && (!ID_taken || ID_always);
      if (!le[3] && m_stall < 65535) n_stall = m_stall + 1;
    end
  endtask

  task automatic half();
    @(negedge clk);
    model_eval();
  endtask

  task automatic adv();
    @(posedge clk);
    m_wait = n_wait; m_err = n_err; m_waited = n_waited; m_annul = n_annul; m_stall = n_stall;
    #1;
  endtask

  task automatic clear_inputs();
    {ID_rs1, ID_rs2, ID_rd, EX_RD, MEM_RD, WB_RD} = '0;
    {ID_use_rs1, ID_use_rs2, ID_use_rd, ID_branch, ID_annul, ID_taken, ID_always} = '0;
    {EX_rf_en, EX_load, MEM_rf_en, MEM_access, WB_rf_en} = '0;
    mem_ready = 1'b1;
  endtask

  task automatic rand_regs();
    ID_rs1 = 5'($urandom_range(0, 7)); ID_rs2 = 5'($urandom_range(0, 7));
    ID_rd  = 5'($urandom_range(0, 7)); EX_RD  = 5'($urandom_range(0, 7));
    MEM_RD = 5'($urandom_range(0, 7)); WB_RD  = 5'($urandom_range(0, 7));
    {ID_use_rs1, ID_use_rs2, ID_use_rd} = 3'($urandom);
    {EX_rf_en, EX_load, MEM_rf_en, WB_rf_en} = 4'($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rand_regs();
    repeat (2) begin
      half();
      n_cmp++;
      if (obs_vec() !== 13'b1111_1_1_000000_0) begin
        n_bad++; $display("FAIL reset_outputs: got %b need %b", obs_vec(), 13'b1111110000000);
      end
      adv();
    end
    reset = 1'b0;
    clear_inputs();
    half();
    n_cmp++;
    if (obs_vec() !== exp_vec) begin
      n_bad++; $display("FAIL reset_release: got %b need %b", obs_vec(), exp_vec);
    end
    adv();
  endtask

  task automatic test_forwarding();
    clear_inputs();
    EX_RD = 5'd3; EX_rf_en = 1'b1; MEM_RD = 5'd3; MEM_rf_en = 1'b1;
    ID_rs2 = 5'd3; ID_use_rs2 = 1'b1;
    half();
    n_cmp++;
    if (fwd_MX2 !== 2'b01) begin
      n_bad++; $display("FAIL fwd_ex_over_mem: got %b need 01", fwd_MX2);
    end
    adv();
    ID_rs2 = 5'd0; EX_RD = 5'd0;
    half();
    n_cmp++;
    if (fwd_MX2 !== 2'b00) begin
      n_bad++; $display("FAIL fwd_r0: got %b need 00", fwd_MX2);
    end
    adv();
    for (int i = 0; i < 40; i++) begin
      rand_regs();
      half();
      n_cmp++;
      if (obs_vec() !== exp_vec) begin
        n_bad++; $display("FAIL fwd_random[%0d]: got %b need %b", i, obs_vec(), exp_vec);
      end
      adv();
    end
  endtask

  task automatic test_load_use();
    clear_inputs();
    EX_load = 1'b1; EX_rf_en = 1'b1; EX_RD = 5'd5; ID_rs1 = 5'd5; ID_use_rs1 = 1'b1;
    half();
    n_cmp++;
    if ({PC_LE, IF_ID_LE, ID_EX_clr, ID_EX_LE, EX_MEM_LE, MEM_WB_clr} !== 6'b001110) begin
      n_bad++; $display("FAIL load_use_bubble: got %b need 001110",
                        {PC_LE, IF_ID_LE, ID_EX_clr, ID_EX_LE, EX_MEM_LE, MEM_WB_clr});
    end
    adv();
    EX_load = 1'b0; EX_rf_en = 1'b0; MEM_RD = 5'd5; MEM_rf_en = 1'b1;
    half();
    n_cmp++;
    if ({fwd_MX1, PC_LE, ID_EX_clr} !== 4'b1010) begin
      n_bad++; $display("FAIL load_use_after: got %b need 1010", {fwd_MX1, PC_LE, ID_EX_clr});
    end
    adv();
  endtask

  task automatic test_annul();
    logic [1:0] cases [3];
    logic       bub   [3];
    cases[0] = 2'b00; bub[0] = 1'b1;
    cases[1] = 2'b10; bub[1] = 1'b0;
    cases[2] = 2'b11; bub[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      clear_inputs();
      ID_branch = 1'b1; ID_annul = 1'b1; {ID_taken, ID_always} = cases[i];
      half();
      n_cmp++;
      if (obs_vec() !== exp_vec) begin
        n_bad++; $display("FAIL annul_branch[%0d]: got %b need %b", i, obs_vec(), exp_vec);
      end
      adv();
      clear_inputs();
      half();
      n_cmp++;
      if (ID_EX_clr !== bub[i] || PC_LE !== 1'b1) begin
        n_bad++; $display("FAIL annul_slot[%0d]: clr %b need %b", i, ID_EX_clr, bub[i]);
      end
      adv();
      half();
      n_cmp++;
      if (ID_EX_clr !== 1'b0) begin
        n_bad++; $display("FAIL annul_cleared[%0d]: clr %b need 0", i, ID_EX_clr);
      end
      adv();
    end
  endtask

  task automatic test_mem_freeze();
    clear_inputs();
    MEM_access = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      half();
      n_cmp++;
      if ({PC_LE, IF_ID_LE, ID_EX_LE, EX_MEM_LE, ID_EX_clr, MEM_WB_clr} !== 6'b000001) begin
        n_bad++; $display("FAIL freeze[%0d]: got %b need 000001", i,
                          {PC_LE, IF_ID_LE, ID_EX_LE, EX_MEM_LE, ID_EX_clr, MEM_WB_clr});
      end
      adv();
    end
    mem_ready = 1'b1;
    half();
    n_cmp++;
    if ({PC_LE, IF_ID_LE, ID_EX_LE, EX_MEM_LE, MEM_WB_clr} !== 5'b11110) begin
      n_bad++; $display("FAIL freeze_release: got %b need 11110",
                        {PC_LE, IF_ID_LE, ID_EX_LE, EX_MEM_LE, MEM_WB_clr});
    end
    adv();
    MEM_access = 1'b0; mem_ready = 1'b0;
    half();
    n_cmp++;
    if (PC_LE !== 1'b1 || obs_vec() !== exp_vec) begin
      n_bad++; $display("FAIL freeze_back_to_run: got %b need %b", obs_vec(), exp_vec);
    end
    adv();
  endtask

  task automatic test_timeout();
    clear_inputs();
    MEM_access = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      half();
      n_cmp++;
      if (mem_timeout !== (i >= 5) || obs_vec() !== exp_vec) begin
        n_bad++; $display("FAIL timeout[%0d]: got %b need %b (timeout %b need %0d)",
                          i, obs_vec(), exp_vec, mem_timeout, (i >= 5));
      end
      adv();
    end
    MEM_access = 1'b0; mem_ready = 1'b1;
    repeat (2) begin
      half();
      n_cmp++;
      if ({mem_timeout, PC_LE, MEM_WB_clr} !== 3'b101) begin
        n_bad++; $display("FAIL err_sticky: got %b need 101", {mem_timeout, PC_LE, MEM_WB_clr});
      end
      adv();
    end
    reset = 1'b1;
    half();
    n_cmp++;
    if (mem_timeout !== 1'b0 || obs_vec() !== exp_vec) begin
      n_bad++; $display("FAIL err_reset: got %b need %b", obs_vec(), exp_vec);
    end
    adv();
    reset = 1'b0;
    half();
    n_cmp++;
    if ({mem_timeout, PC_LE} !== 2'b01) begin
      n_bad++; $display("FAIL err_cleared: got %b need 01", {mem_timeout, PC_LE});
    end
    adv();
  endtask

  task automatic test_freeze_loaduse();
    clear_inputs();
    EX_load = 1'b1; EX_rf_en = 1'b1; EX_RD = 5'd7; ID_rd = 5'd7; ID_use_rd = 1'b1;
    MEM_access = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      half();
      n_cmp++;
      if ({PC_LE, ID_EX_LE, ID_EX_clr, MEM_WB_clr} !== 4'b0001) begin
        n_bad++; $display("FAIL freeze_wins[%0d]: got %b need 0001", i,
                          {PC_LE, ID_EX_LE, ID_EX_clr, MEM_WB_clr});
      end
      adv();
    end
    mem_ready = 1'b1;
    half();
    n_cmp++;
    if ({PC_LE, ID_EX_LE, ID_EX_clr, MEM_WB_clr} !== 4'b0110) begin
      n_bad++; $display("FAIL loaduse_after_freeze: got %b need 0110",
                        {PC_LE, ID_EX_LE, ID_EX_clr, MEM_WB_clr});
    end
    adv();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rand_regs();
      reset      = ($urandom_range(0, 99) < 4);
      MEM_access = ($urandom_range(0, 99) < 25);
      mem_ready  = ($urandom_range(0, 99) < 65);
      ID_branch  = ($urandom_range(0, 99) < 40);
      {ID_annul, ID_taken, ID_always} = 3'($urandom);
      half();
      n_cmp++;
      if (obs_vec() !== exp_vec) begin
        n_bad++; $display("FAIL random[%0d]: got %b need %b", i, obs_vec(), exp_vec);
      end
`ifdef HAZARD_STATS_EN
      n_cmp++;
      if (stall_cycles !== 16'(m_stall)) begin
        n_bad++; $display("FAIL stall_cycles[%0d]: got %0d need %0d", i, stall_cycles, m_stall);
      end
`endif
      adv();
    end
    reset = 1'b0;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    test_reset();
    test_forwarding();
    test_load_use();
    test_annul();
    test_mem_freeze();
    test_timeout();
    test_freeze_loaduse();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
